// File: rtl/stream_select_mux.sv
// ---------------------------------------------------------------------------
// stream_select_mux
//   Registered N-channel stream multiplexer. One input word is chosen per
//   cycle, either by an explicit channel select (MODE 0) or by round-robin
//   arbitration among the valid inputs (MODE 1). The winner is held in a
//   one-deep output register with a valid/ready handshake.
//
// Parameters
//   SIZE      data width of each channel word
//   CHANNELS  number of input channels (2..16)
//   MODE      0 = explicit select via sel, 1 = round-robin (sel ignored)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      packed input words, channel i at [i*SIZE +: SIZE]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (combinational, at most one bit set)
//   sel          explicit channel select (MODE 0 only)
//   out_data     registered selected word
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer takes out_data this cycle
//   out_channel  index of the channel that produced out_data
// ---------------------------------------------------------------------------
module stream_select_mux #(
  parameter int SIZE     = 64,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_channel
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SIZE-1:0]  out_data_q,    out_data_d;
  logic             out_valid_q,   out_valid_d;
  logic [SEL_W-1:0] out_channel_q, out_channel_d;
  logic [SEL_W-1:0] last_q,        last_d;

  logic             load_s;
  logic             sel_ok_s;
  logic             rr_found_s;
  logic             rr_hit_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic [SEL_W-1:0] rr_probe_s;
  logic             cand_ok_s;
  logic [SEL_W-1:0] cand_idx_s;
  logic [SIZE-1:0]  cand_word_s;
  logic             xfer_s;

  // The output register can take a new word when empty or draining now.
  assign load_s = !out_valid_q || out_ready;

  // Explicit select: a select value beyond the last channel matches no
  // channel, so it never produces a candidate.
  always_comb begin
    sel_ok_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_ok_s = sel_ok_s | ((sel == SEL_W'(i)) & in_valid[i]);
    end
  end

  // Round-robin search: walk from last+1 with an explicit wrap so that a
  // non-power-of-two channel count never probes a nonexistent channel.
  always_comb begin
    rr_found_s = 1'b0;
    rr_hit_s   = 1'b0;
    rr_idx_s   = '0;
    rr_probe_s = last_q;
    for (int k = 0; k < CHANNELS; k++) begin
      rr_probe_s = (rr_probe_s == LAST_CH) ? '0 : rr_probe_s + SEL_W'(1);
      rr_hit_s   = !rr_found_s && in_valid[rr_probe_s];
      rr_idx_s   = rr_hit_s ? rr_probe_s : rr_idx_s;
      rr_found_s = rr_found_s | rr_hit_s;
    end
  end

  // Pick the candidate channel according to the arbitration mode.
  always_comb begin
    if (MODE == 1) begin
      cand_ok_s  = rr_found_s;
      cand_idx_s = rr_idx_s;
    end else begin
      cand_ok_s  = sel_ok_s;
      cand_idx_s = sel;
    end
  end

  assign xfer_s = load_s && cand_ok_s;

  // One-hot ready towards the winning producer; no dependence on in_data.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer_s && (cand_idx_s == SEL_W'(i));
    end
  end

  // Data mux for the candidate word.
  always_comb begin
    cand_word_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand_word_s = (cand_idx_s == SEL_W'(i)) ? in_data[i*SIZE +: SIZE] : cand_word_s;
    end
  end

  // Next-state for the output register and the round-robin pointer.
  // A refill in the same edge as a drain replaces the word directly.
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    last_d        = last_q;
    if (xfer_s) begin
      out_data_d    = cand_word_s;
      out_channel_d = cand_idx_s;
      out_valid_d   = 1'b1;
      last_d        = (MODE == 1) ? cand_idx_s : last_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d   = 1'b0;
    end else begin
      out_valid_d   = out_valid_q;
    end
  end

  // State registers; reset drops any held word and gives channel 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      last_q        <= LAST_CH;
    end else begin
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      last_q        <= last_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;

endmodule

// File: doc/stream_select_mux.md
Name: stream_select_mux

Overview:
- Parametrised N-channel, registered successor to the combinational 4-way datapath mux.
- Selects one of CHANNELS input words, either by an explicit select or by round-robin arbitration among valid inputs.
- Holds the winner in a one-deep output register with valid/ready handshake on every side.
- Used wherever several producers (forwarding paths, writeback sources, memory-return ports) share one pipeline consumer.

Parameters:
- SIZE, 64 (`WORD`): data width per channel.
- CHANNELS, 4: number of input channels; legal values are 2 to 16.
- MODE, 0: 0 = explicit select via sel; 1 = round-robin arbitration, sel ignored.
- SEL_W (localparam): $clog2(CHANNELS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*SIZE  packed words; channel i occupies bits [i*SIZE +: SIZE].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- sel  input  SEL_W  channel select (MODE 0 only).
- out_data  output  SIZE  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_channel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_channel=0.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority after reset.
  - Reset mid-operation discards the held word immediately; no partial transfer survives.
- Load condition: load = !out_valid || out_ready (register empty or draining this cycle).
- Grant, MODE 0:
  - Candidate is channel sel.
  - grant[sel] = load && in_valid[sel].
  - If sel >= CHANNELS, nothing is granted and all in_ready=0.
- Grant, MODE 1:
  - Search in_valid starting at last+1, wrapping modulo CHANNELS.
  - The first valid channel found is the candidate; grant = load && any valid.
- in_ready:
  - in_ready[i] = grant[i]; at most one bit is high.
  - in_ready is a function of in_valid, sel, out_valid, out_ready and last. It never depends on in_data.
- Transfer on input channel i when in_valid[i] && in_ready[i] at a clock edge:
  - out_data <= word i, out_channel <= i, out_valid <= 1.
  - MODE 1 only: last <= i.
- Drain without refill: out_valid && out_ready with no grant sets out_valid <= 0. out_data and out_channel keep their old values.
- Simultaneous drain and refill: the new word replaces the old one in the same edge, which sustains 1 word/cycle throughput.
- Stall: out_valid && !out_ready holds out_data, out_valid and out_channel stable. All in_ready=0 and last is unchanged.
- Latency: 1 cycle from the input handshake to out_valid.
- Pointer behaviour: last advances only on a grant. Idle cycles do not rotate priority.
- Fairness (MODE 1): with every channel continuously valid, grants cycle 0,1,...,CHANNELS-1,0...
- Width rules: no arithmetic on data. Pointer wrap is (last==CHANNELS-1) ? 0 : last+1, which is correct for non-power-of-two CHANNELS.

Test Plan:
- Reset: rst_n=0 asserted mid-stream with out_valid=1 → out_valid=0, out_data=0, out_channel=0 asynchronously, before the next edge.
- MODE 0, CHANNELS=4, SIZE=64: in_data ch2=64'hDEAD_BEEF, sel=2, in_valid=4'b0100, out_ready=1.
  - Same cycle: in_ready=4'b0100.
  - Next cycle: out_data=64'hDEAD_BEEF, out_valid=1, out_channel=2.
  - With sel=3 and in_valid[3]=0: in_ready=0.
- MODE 1 fairness: in_valid=4'b1111 held, out_ready=1 for 8 cycles → out_channel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
- MODE 1 skip and hold:
  - After granting ch1, set in_valid=4'b0001 → next grant is ch0.
  - With last=1, in_valid=4'b1001 → grant goes to ch3.
  - Idle cycles with in_valid=0 leave last unchanged.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 → in_ready=0 and out_data stable throughout. Raising out_ready refills in the same edge, with no bubble.
- Non-power-of-two: CHANNELS=3, MODE 1, all valid → grants 0,1,2,0; last never reaches 3.
